// File: rtl/cp0_unit_pkg.sv
// -----------------------------------------------------------------------------
// cp0_unit_pkg
// Shared definitions for the coprocessor-0 block of the multicycle CPU.
// Contents:
//   - CP0 register indices (SR, Cause, EPC, PRId)
//   - SR/Cause bit positions and the number of hardware interrupt lines
//   - helper functions that assemble the architectural SR/Cause read views
// -----------------------------------------------------------------------------
package cp0_unit_pkg;

   // Register indices as they appear in instr[15:11]
   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   // SR field positions (Cause uses the same 15:10 slot for IP)
   localparam int IM_HI   = 15;
   localparam int IM_LO   = 10;
   localparam int EXL_BIT = 1;
   localparam int IE_BIT  = 0;

   localparam int NUM_HWINT = 6;

   // SR read view: {16'b0, IM, 8'b0, EXL, IE}
   function automatic logic [31:0] packSr(input logic [NUM_HWINT-1:0] im,
                                          input logic exl,
                                          input logic ie);
      return {16'b0, im, 8'b0, exl, ie};
   endfunction

   // Cause read view: {16'b0, IP, 10'b0}
   function automatic logic [31:0] packCause(input logic [NUM_HWINT-1:0] ip);
      return {16'b0, ip, 10'b0};
   endfunction

endpackage

// File: rtl/cp0_unit_sync.sv
// -----------------------------------------------------------------------------
// cp0_unit_sync
// Multi-bit flop-chain synchroniser for asynchronous level-sensitive lines.
// Every bit is independent; no multi-bit coherency is implied.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low clear of every stage
//   i_async  - asynchronous input lines
//   o_sync   - lines after STAGES flops
// Parameters:
//   WIDTH    - number of lines
//   STAGES   - chain depth (2 or 3)
// -----------------------------------------------------------------------------
module cp0_unit_sync #(
   parameter int WIDTH  = 6,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [STAGES-1:0][WIDTH-1:0] r_chain;

   // Shift chain: stage 0 samples the raw line, the last stage is the output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit
// Coprocessor 0: SR, Cause, EPC and PRId registers plus hardware interrupt
// synchronisation and the interrupt request to the controller FSM.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   i_pc       - PC[31:2], captured into EPC on interrupt entry
//   i_dIn      - mtc0 write data
//   i_a        - CP0 register index (instr[15:11])
//   i_we       - mtc0 write enable (controller CP0Wr)
//   i_exlSet   - interrupt entry strobe (controller exlset)
//   i_exlClr   - eret strobe (controller exlclr), may be held several cycles
//   i_hwInt    - asynchronous device interrupt lines HWInt[7:2]
//   o_intReq   - interrupt request to the controller
//   o_epc      - exception return address [31:2]
//   o_dOut     - mfc0 read data for register i_a
// -----------------------------------------------------------------------------
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] PRID        = 32'h0000_0001,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:2] i_pc,
   input  logic [31:0] i_dIn,
   input  logic [4:0]  i_a,
   input  logic        i_we,
   input  logic        i_exlSet,
   input  logic        i_exlClr,
   input  logic [7:2]  i_hwInt,
   output logic        o_intReq,
   output logic [31:2] o_epc,
   output logic [31:0] o_dOut
);

   logic [NUM_HWINT-1:0] r_im;
   logic                 r_exl;
   logic                 r_ie;
   logic [31:2]          r_epc;
   logic [NUM_HWINT-1:0] r_ip;

   logic [NUM_HWINT-1:0] w_syncOut;
   logic                 w_srWr;
   logic                 w_epcWr;

   assign w_srWr  = i_we && (i_a == CP0_SR);
   assign w_epcWr = i_we && (i_a == CP0_EPC);

   cp0_unit_sync #(
      .WIDTH  (NUM_HWINT),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (i_hwInt),
      .o_sync  (w_syncOut)
   );

   // Pending bits follow the synchronised lines every cycle; Cause writes
   // are deliberately ignored so software cannot fake or clear a pending line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ip <= '0;
      end else begin
         r_ip <= w_syncOut;
      end
   end

   // IM and IE only change through mtc0 to SR; interrupt entry leaves them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_im <= '0;
         r_ie <= 1'b0;
      end else if (w_srWr) begin
         r_im <= i_dIn[IM_HI:IM_LO];
         r_ie <= i_dIn[IE_BIT];
      end
   end

   // EXL: entry beats eret beats software write, so a late mtc0 cannot
   // re-open interrupts during the entry cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exl <= 1'b0;
      end else if (i_exlSet) begin
         r_exl <= 1'b1;
      end else if (i_exlClr) begin
         r_exl <= 1'b0;
      end else if (w_srWr) begin
         r_exl <= i_dIn[EXL_BIT];
      end
   end

   // EPC: hardware capture of the interrupted PC beats an mtc0 to EPC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_epc <= '0;
      end else if (i_exlSet) begin
         r_epc <= i_pc;
      end else if (w_epcWr) begin
         r_epc <= i_dIn[31:2];
      end
   end

   assign o_intReq = (|(r_ip & r_im)) & r_ie & ~r_exl;
   assign o_epc    = r_epc;

   // Read mux reflects registered state only, so a same-cycle write is not
   // visible until after the edge.
   always_comb begin
      o_dOut = 32'h0;
      case (i_a)
         CP0_SR:    o_dOut = packSr(r_im, r_exl, r_ie);
         CP0_CAUSE: o_dOut = packCause(r_ip);
         CP0_EPC:   o_dOut = {r_epc, 2'b00};
         CP0_PRID:  o_dOut = PRID;
         default:   o_dOut = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_unit
// Self-checking bench for cp0_unit: directed scenarios followed by random
// traffic, all compared against a register-level behavioural model.
// -----------------------------------------------------------------------------
module tb_cp0_unit;

   localparam logic [31:0] PRID_VAL = 32'h0042_0001;
   localparam int          SYNC     = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:2] pc;
   logic [31:0] dIn;
   logic [4:0]  a;
   logic        we;
   logic        exlSet;
   logic        exlClr;
   logic [7:2]  hwInt;
   logic        intReq;
   logic [31:2] epc;
   logic [31:0] dOut;

   int checkCount = 0;
   int errorCount = 0;

   // Behavioural model state
   logic [5:0]  mIm;
   logic        mExl;
   logic        mIe;
   logic [29:0] mEpc;
   logic [5:0]  mIp;
   logic [5:0]  hist[$];

   cp0_unit #(
      .PRID        (PRID_VAL),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_pc     (pc),
      .i_dIn    (dIn),
      .i_a      (a),
      .i_we     (we),
      .i_exlSet (exlSet),
      .i_exlClr (exlClr),
      .i_hwInt  (hwInt),
      .o_intReq (intReq),
      .o_epc    (epc),
      .o_dOut   (dOut)
   );

   always #5 clk = ~clk;

   // Single comparison point; every check is counted here
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed,
                  expected, $time);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [4:0] idx);
      case (idx)
         5'd12:   return {16'b0, mIm, 8'b0, mExl, mIe};
         5'd13:   return {16'b0, mIp, 10'b0};
         5'd14:   return {mEpc, 2'b00};
         5'd15:   return PRID_VAL;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic modelIntReq();
      return (|(mIp & mIm)) && mIe && !mExl;
   endfunction

   task automatic modelReset();
      mIm  = '0;
      mExl = 1'b0;
      mIe  = 1'b0;
      mEpc = '0;
      mIp  = '0;
      hist = {};
      for (int i = 0; i <= SYNC; i++) hist.push_back(6'b0);
   endtask

   // One clock edge of the architectural rules; hist[k] is the line value
   // sampled k edges ago, so hist[SYNC] is what has just reached IP.
   task automatic modelEdge();
      if (we && a == 5'd12) begin
         mIm = dIn[15:10];
         mIe = dIn[0];
      end
      if (exlSet)                  mExl = 1'b1;
      else if (exlClr)             mExl = 1'b0;
      else if (we && a == 5'd12)   mExl = dIn[1];
      if (exlSet)                  mEpc = pc;
      else if (we && a == 5'd14)   mEpc = dIn[31:2];
      hist.push_front(hwInt);
      void'(hist.pop_back());
      mIp = hist[SYNC];
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".intReq"}, {31'b0, intReq}, {31'b0, modelIntReq()});
      checkOutput({tag, ".epc"}, {epc, 2'b00}, {mEpc, 2'b00});
      checkOutput({tag, ".dOut"}, dOut, modelRead(a));
   endtask

   // Drive one cycle of inputs, clock it, then compare after the edge
   task automatic applyStimulus(input logic w, input logic [4:0] idx,
                                input logic [31:0] d, input logic es,
                                input logic ec, input logic [5:0] hw,
                                input logic [29:0] p, input string tag);
      @(negedge clk);
      we = w; a = idx; dIn = d; exlSet = es; exlClr = ec; hwInt = hw; pc = p;
      @(posedge clk);
      modelEdge();
      #1;
      checkAll(tag);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      we = 0; a = 5'd12; dIn = '0; exlSet = 0; exlClr = 0; hwInt = '0; pc = '0;
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int firstHigh;

   initial begin
      rst_n = 1'b1;
      we = 0; a = '0; dIn = '0; exlSet = 0; exlClr = 0; hwInt = '0; pc = '0;
      modelReset();
      doReset();

      // Reset read-back
      for (int i = 12; i <= 15; i++) begin
         @(negedge clk);
         a = 5'(i);
         #1;
         checkOutput("resetRead", dOut, (i == 15) ? PRID_VAL : 32'h0);
      end
      checkOutput("resetIntReq", {31'b0, intReq}, 32'h0);

      // Interrupt path and latency
      applyStimulus(1, 5'd12, 32'h0000_0401, 0, 0, 6'b0, '0, "srWrite");
      firstHigh = 0;
      for (int i = 1; i <= SYNC + 4; i++) begin
         applyStimulus(0, 5'd13, '0, 0, 0, 6'b000001, '0, "intPath");
         if (intReq && firstHigh == 0) firstHigh = i;
      end
      checkOutput("intLatency", firstHigh, SYNC + 1);
      checkOutput("causeRead", dOut, 32'h0000_0400);

      // Masking: pending visible, request suppressed
      doReset();
      applyStimulus(1, 5'd12, 32'h0000_0001, 0, 0, 6'b0, '0, "srMasked");
      for (int i = 0; i < SYNC + 3; i++)
         applyStimulus(0, 5'd13, '0, 0, 0, 6'b000001, '0, "masked");
      checkOutput("maskedIntReq", {31'b0, intReq}, 32'h0);
      checkOutput("maskedCause", dOut, 32'h0000_0400);

      // Entry and return
      doReset();
      applyStimulus(1, 5'd12, 32'h0000_0401, 0, 0, 6'b0, '0, "srEntry");
      for (int i = 0; i < SYNC + 2; i++)
         applyStimulus(0, 5'd12, '0, 0, 0, 6'b000001, '0, "preEntry");
      checkOutput("preEntryIntReq", {31'b0, intReq}, 32'h1);
      applyStimulus(0, 5'd12, '0, 1, 0, 6'b000001, 30'h0000_0C05, "entry");
      checkOutput("entryEpc", {epc, 2'b00}, 32'h0000_3014);
      checkOutput("entrySr", dOut, 32'h0000_0403);
      checkOutput("entryIntReq", {31'b0, intReq}, 32'h0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 5'd12, '0, 0, 1, 6'b000001, 30'h0000_0C05, "eret");
      checkOutput("eretSr", dOut, 32'h0000_0401);
      checkOutput("eretIntReq", {31'b0, intReq}, 32'h1);

      // Simultaneous events: entry wins for EXL and EPC
      applyStimulus(1, 5'd14, 32'hFFFF_FFFC, 1, 1, 6'b000001, 30'h0123_4567,
                    "simul");
      checkOutput("simulEpc", dOut, 32'h048D_159C);
      applyStimulus(0, 5'd12, '0, 0, 0, 6'b000001, 30'h0, "simulSr");
      checkOutput("simulExl", dOut, 32'h0000_0403);

      // Async reset mid-handler, between edges
      @(negedge clk);
      a = 5'd14;
      @(posedge clk);
      modelEdge();
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("asyncIntReq", {31'b0, intReq}, 32'h0);
      checkOutput("asyncEpc", {epc, 2'b00}, 32'h0);
      checkOutput("asyncEpcRead", dOut, 32'h0);
      a = 5'd12;
      #1;
      checkOutput("asyncSr", dOut, 32'h0);
      a = 5'd13;
      #1;
      checkOutput("asyncCause", dOut, 32'h0);
      hwInt = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [4:0]  rIdx;
         logic [5:0]  rHw;
         rHw = hwInt;
         if ($urandom_range(0, 3) == 0) rHw = 6'($urandom);
         case ($urandom_range(0, 4))
            0:       rIdx = 5'd12;
            1:       rIdx = 5'd13;
            2:       rIdx = 5'd14;
            3:       rIdx = 5'd15;
            default: rIdx = 5'($urandom_range(0, 31));
         endcase
         applyStimulus($urandom_range(0, 3) == 0, rIdx, $urandom,
                       $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                       rHw, 30'($urandom), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount,
               errorCount);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the multicycle CPU: holds the SR, Cause, EPC and PRId registers, synchronises six external hardware interrupt lines and raises `IntReq` to the controller FSM. It sits beside the controller and datapath.
- Inputs from the controller: `CP0Wr`, `exlset`, `exlclr`.
- Inputs from the datapath: write data after the `cp0sel` mux, current PC, register index `instr[15:11]`.
- Outputs: `IntReq` back to the controller; `EPC` to the PC-next mux; read data to the `memtoreg` mux for `mfc0`.

## Interface
Parameters:
- `PRID`, default 32'h0000_0001: value returned when reading PRId (reg 15).
- `SYNC_STAGES`, default 2: flop depth of the `HWInt` synchroniser. Legal values are 2 or 3.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `PC`  in  [31:2]: PC value captured into EPC on interrupt entry.
- `DIn`  in  32: write data for `mtc0`.
- `A`  in  5: CP0 register index, taken from `instr[15:11]`.
- `We`  in  1: write enable, driven by controller `CP0Wr`.
- `EXLSet`  in  1: interrupt entry, driven by controller `exlset` (state s10).
- `EXLClr`  in  1: `eret`, driven by controller `exlclr`.
- `HWInt`  in  [7:2]: asynchronous, level-sensitive device interrupt lines.
- `IntReq`  out  1: interrupt request to the controller.
- `EPC`  out  [31:2]: exception return address.
- `DOut`  out  32: read data for register `A`.

## Operation
Register map, selected by `A`:
- Reg 12, SR = {16'b0, IM[15:10], 8'b0, EXL, IE}.
- Reg 13, Cause = {16'b0, IP[15:10], 10'b0}.
- Reg 14, EPC = {EPC[31:2], 2'b00}.
- Reg 15, PRId = `PRID`.
- Any other index reads 32'h0.

Synchroniser and pending bits:
- Each `HWInt` bit passes through a `SYNC_STAGES`-deep flop chain.
- The synchroniser output is registered into `IP` every cycle.
- `IP` is read-only; writes to Cause are ignored.

`IntReq = |(IP & IM) & IE & !EXL`. This is purely combinational from registered state.

Writes on a `We` edge:
- A=12 loads IM←DIn[15:10], EXL←DIn[1], IE←DIn[0].
- A=14 loads EPC←DIn[31:2].
- All other indices have no effect.

`EXLSet` edge: EPC←PC and EXL←1. IM and IE are unchanged.

`EXLClr` edge: EXL←0.

Write priority per field, applied in the same cycle:
- EXL: `EXLSet` > `EXLClr` > `We`.
- EPC: `EXLSet` > `We`.

`EXLClr` may be held for several cycles, for the whole `eret` instruction. EXL stays 0 throughout and no other state changes.

`DOut` is a combinational read of the current register values. There is no write-through: a read in the same cycle as a write returns the old value.

## Timing
Reset, with `rst_n` low, asynchronously clears:
- SR = 0 (IM, EXL, IE all 0).
- IP = 0, and all synchroniser flops = 0.
- EPC = 0.
- `IntReq` = 0.

`DOut` after reset is 0 for A∈{12,13,14} and `PRID` for A=15.

Interrupt latency: a `HWInt` rising edge reaches `IP` after `SYNC_STAGES`+1 edges. `IntReq` goes high in the same cycle `IP` updates, provided IM, IE and !EXL allow it.

FSM interaction:
- The controller samples `IntReq` in states s4/s5/s7/s8/s9 and enters s10 on the next edge.
- In s10, `EXLSet` is high for exactly one cycle. At that edge EXL←1, and `IntReq` drops in the following cycle.

A device deasserting `HWInt` before the controller samples it clears `IP`. No interrupt is taken; this is by design, since lines are level-sensitive.

A reset asserted mid-handler (EXL=1) returns every register to its reset value. EPC content is lost.

## Structure
- Shared package/header (`head.v`) holds:
  - CP0 register indices `CP0_SR`=12, `CP0_CAUSE`=13, `CP0_EPC`=14, `CP0_PRID`=15.
  - SR bit positions: IM 15:10, EXL 1, IE 0.
- One sub-module, `cp0_sync`: a parameterised-width, `SYNC_STAGES`-deep flop synchroniser with async active-low clear. It is instantiated once with width 6.

## Test plan
- **Reset read-back:** release `rst_n`, read A=12/13/14/15 → 0, 0, 0, `PRID`; `IntReq`=0.
- **Interrupt path:** write SR=32'h0000_0401 (IM[10]=1, IE=1), then pulse `HWInt[2]` high and hold → `IntReq` high exactly `SYNC_STAGES`+1 edges later; Cause reads 32'h0000_0400.
- **Masking:** repeat the interrupt path with SR=32'h0000_0001 (IM=0) → `IntReq` stays 0 while Cause still shows 32'h0000_0400.
- **Entry and return:** with `IntReq` high and PC=30'h0000_0C05, pulse `EXLSet` → EPC=30'h0000_0C05, SR bit1=1, `IntReq`=0 next cycle. Hold `EXLClr` 3 cycles → EXL=0 and `IntReq` returns to 1.
- **Simultaneous events:** assert `EXLSet`, `EXLClr`, and `We` to A=14 with DIn=32'hFFFF_FFFC in one cycle → EXL=1, EPC=PC (`EXLSet` wins).
- **Async reset mid-handler:** with EXL=1 and EPC nonzero, drop `rst_n` between clock edges → all registers and `IntReq` are 0 immediately, before the next edge.
